// File: rtl/free_list_pkg.sv
// Shared rename-stage types: physical register counts and the free-list entry type.
package rv32i_types;

   localparam int PREG_COUNT = 64;
   localparam int ARCH_COUNT = 32;
   localparam int PHYS_W     = $clog2(PREG_COUNT);
   localparam int FL_W       = 8;
   localparam int FL_DEPTH   = PREG_COUNT - ARCH_COUNT;
   localparam int FL_CNT_W   = $clog2(FL_DEPTH + 1);

   // One free-list slot; upper bits above PHYS_W must be zero for a legal entry.
   typedef logic [FL_W-1:0] free_list_t;

endpackage

// File: rtl/free_list_if.sv
// Rename/commit <-> free list handshake bundle.
interface free_list_if;
   import rv32i_types::*;

   logic                deq_en;
   free_list_t          deq_reg;
   logic                deq_valid;
   logic                enq_en;
   free_list_t          enq_reg;
   logic                full;
   logic [FL_CNT_W-1:0] count;
   logic                overflow_err;

   // Rename/commit side.
   modport master (
      output deq_en, enq_en, enq_reg,
      input  deq_reg, deq_valid, full, count, overflow_err
   );

   // Free list itself.
   modport slave (
      input  deq_en, enq_en, enq_reg,
      output deq_reg, deq_valid, full, count, overflow_err
   );

endinterface

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of free preg indices, show-ahead head.
module free_list #(
   parameter int PREG_COUNT = rv32i_types::PREG_COUNT,
   parameter int ARCH_COUNT = rv32i_types::ARCH_COUNT
) (
   input  logic        clk,
   input  logic        rst,
   free_list_if.slave  fl
);
   import rv32i_types::*;

   localparam int DEPTH = PREG_COUNT - ARCH_COUNT;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(PREG_COUNT);

   free_list_t       mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             overflow_err;

   logic             deq_ok;
   logic             enq_ok;
   logic             enq_legal;
   logic             enq_err;

   // Pointer advance with explicit wrap so non-power-of-two depths also work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Accept/reject decisions; a full list still takes an enqueue when the head leaves.
   always_comb begin
      deq_ok    = fl.deq_en && (count != '0);
      enq_legal = (fl.enq_reg[IDX_W-1:0] != '0) && (fl.enq_reg[FL_W-1:IDX_W] == '0);
      enq_ok    = fl.enq_en && enq_legal && ((count != CNT_W'(DEPTH)) || deq_ok);
      enq_err   = fl.enq_en && (fl.enq_reg != '0) && !enq_ok;
   end

   // Storage: reset refills with the preg indices not held by the architectural map.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= free_list_t'(ARCH_COUNT + i);
      end else if (enq_ok) begin
         mem[tail] <= fl.enq_reg;
      end
   end

   // Pointers, occupancy and the sticky illegal-enqueue flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= CNT_W'(DEPTH);
         overflow_err <= 1'b0;
      end else begin
         if (deq_ok) head <= ptr_inc(head);
         if (enq_ok) tail <= ptr_inc(tail);
         case ({enq_ok, deq_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (enq_err) overflow_err <= 1'b1;
      end
   end

   assign fl.deq_reg      = mem[head];
   assign fl.deq_valid    = (count != '0);
   assign fl.full         = (count == CNT_W'(DEPTH));
   assign fl.count        = count;
   assign fl.overflow_err = overflow_err;

endmodule
